// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default PC geometry, the control-unit op
// encoding and the fixed priority used when several PC requests coincide.
package cpu_pkg;

    localparam int unsigned PC_WIDTH     = 8;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VEC = '0;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_INC  = 3'd1,
        OP_LOAD = 3'd2,
        OP_REL  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

    localparam int unsigned OP_COUNT  = 6;
    localparam int unsigned OP_PRIO_N = 5;

    // Highest priority first.
    localparam op_e OP_PRIORITY [OP_PRIO_N] = '{OP_RET, OP_CALL, OP_LOAD, OP_REL, OP_INC};

    // Walk from lowest to highest priority so the last hit is the winner.
    function automatic op_e pick_op(input logic [OP_COUNT-1:0] req);
        op_e sel;
        sel = OP_NONE;
        for (int unsigned i = OP_PRIO_N; i > 0; i--) begin
            if (req[OP_PRIORITY[i-1]]) begin
                sel = OP_PRIORITY[i-1];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO for pc_unit. Pushes while full and pops while
// empty are ignored; empty/full are registered from the next pointer value.
module pc_ret_stack
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_val,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    logic [AW:0]      sp;
    logic [AW:0]      sp_next;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];

    always_comb begin
        sp_next = sp;
        if (do_pop) begin
            sp_next = sp - (AW+1)'(1);
        end else if (do_push) begin
            sp_next = sp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            sp    <= sp_next;
            empty <= (sp_next == '0);
            full  <= (sp_next == SP_FULL);
        end
    end

    // Entries are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[sp[AW-1:0]] <= push_val;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: inc / jump / relative branch / call / return with an
// internal return stack, a registered bus copy of the PC and sticky stack errors.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH       = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter int unsigned STEP        = 1,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic             rel,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] offset,
    input  logic             out_enable,
    input  logic             clr_err,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] outp,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [OP_COUNT-1:0] req;
    op_e                 op;
    logic [WIDTH-1:0]    pc_next;
    logic [WIDTH-1:0]    ret_addr;
    logic [WIDTH-1:0]    stack_top;
    logic                push;
    logic                pop;
    logic                ovf_set;
    logic                unf_set;

    always_comb begin
        req          = '0;
        req[OP_INC]  = inc;
        req[OP_LOAD] = load;
        req[OP_REL]  = rel;
        req[OP_CALL] = call;
        req[OP_RET]  = ret;
    end

    assign op       = pick_op(req);
    assign push     = (op == OP_CALL);
    assign pop      = (op == OP_RET);
    assign ret_addr = pc + STEP_V;
    assign ovf_set  = push && stack_full;
    assign unf_set  = pop && stack_empty;

    pc_ret_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .push_val (ret_addr),
        .top      (stack_top),
        .empty    (stack_empty),
        .full     (stack_full)
    );

    always_comb begin
        pc_next = pc;
        unique case (op)
            OP_INC:  pc_next = pc + STEP_V;
            OP_LOAD: pc_next = load_val;
            OP_REL:  pc_next = pc + offset;
            OP_CALL: pc_next = load_val;
            OP_RET:  pc_next = stack_empty ? pc : stack_top;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_VEC;
            outp          <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pc <= pc_next;
            if (out_enable) begin
                outp <= pc;
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow_err  <= ovf_set | (overflow_err & ~clr_err);
            underflow_err <= unf_set | (underflow_err & ~clr_err);
        end
    end

endmodule
